// File: rtl/memory_game_ctrl.sv
// memory_game_ctrl
// ----------------
// Controller for a "repeat the pattern" memory game.  Each round a random
// pattern of L elements is generated from a free-running LFSR, shown on the
// LEDs one element at a time, and then has to be replayed on the buttons.
// A round is won on the L-th correct press.  It is lost on a wrong press,
// on a multi-button press, or when too many ticks pass without any press.
// A game consists of N_ROUNDS rounds.  The score is win_cnt*PTS.
//
// Strobe protocol: tick, start and every btn bit are 1-cycle pulses.  They
// are acted on only in the cycle they are high.  There is no back-pressure.
// A strobe that arrives in a state that does not use it is dropped.
//
// Ports
//   clk        : single clock
//   rst        : asynchronous, active-low reset
//   tick       : 1-cycle timing strobe (10 Hz)
//   start      : 1-cycle game start request (honoured in IDLE/DONE only)
//   level      : one-hot difficulty (001/010/100), sampled with start
//   btn        : debounced 1-cycle button press pulses
//   led        : pattern display; mirrors btn while the player is replaying
//   round_cnt  : completed rounds in the current game
//   win_cnt    : won rounds in the current game
//   score      : registered win_cnt*PTS, one cycle behind win_cnt
//   round_win  : 1-cycle pulse when a round is won
//   round_lose : 1-cycle pulse when a round is lost
//   busy       : a game is in progress (not IDLE, not DONE)
//   game_done  : all rounds played; the final score is held
//
// Legal parameter ranges: N_BTN is a power of 2 in 2..16.  MAX_LEN is a
// multiple of 4 in 4..32.  63*PTS must fit in 10 bits.
module memory_game_ctrl #(
  parameter int N_BTN         = 8,
  parameter int MAX_LEN       = 16,
  parameter int N_ROUNDS      = 10,
  parameter int SHOW_TICKS    = 5,
  parameter int TIMEOUT_TICKS = 100,
  parameter int PTS           = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic [2:0]       level,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] led,
  output logic [5:0]       round_cnt,
  output logic [5:0]       win_cnt,
  output logic [9:0]       score,
  output logic             round_win,
  output logic             round_lose,
  output logic             busy,
  output logic             game_done
);

  localparam int GAP_TICKS = 10;
  localparam int BW        = $clog2(N_BTN);    // bits per pattern element
  localparam int AW        = $clog2(MAX_LEN);  // pattern RAM address width
  localparam int MAX_T     = (TIMEOUT_TICKS > SHOW_TICKS)
                             ? ((TIMEOUT_TICKS > GAP_TICKS) ? TIMEOUT_TICKS : GAP_TICKS)
                             : ((SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS);
  localparam int CW        = $clog2(MAX_T + 1);

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GEN      = 3'd1,
    S_SHOW_ON  = 3'd2,
    S_SHOW_OFF = 3'd3,
    S_INPUT    = 3'd4,
    S_CHECK    = 3'd5,
    S_GAP      = 3'd6,
    S_DONE     = 3'd7
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;       // shared tick counter: show, timeout, gap
  logic [2:0]      level_q, level_d;
  logic [5:0]      round_cnt_q, round_cnt_d;
  logic [5:0]      win_cnt_q, win_cnt_d;
  logic [9:0]      score_q, score_d;
  logic            won_q, won_d;       // outcome carried into CHECK

  logic [BW-1:0]   pat_q [MAX_LEN];

  logic            level_ok;
  logic [AW-1:0]   last_idx;
  logic [N_BTN-1:0] exp_btn;
  logic            idx_at_last;

  assign level_ok = (level == 3'b001) || (level == 3'b010) || (level == 3'b100);

  // Index of the last pattern element for the latched level.
  always_comb begin
    last_idx = AW'(MAX_LEN - 1);
    if (level_q[0]) begin
      last_idx = AW'(MAX_LEN / 2 - 1);
    end else if (level_q[1]) begin
      last_idx = AW'(3 * MAX_LEN / 4 - 1);
    end
  end

  assign idx_at_last = (idx_q == last_idx);
  assign exp_btn     = {{(N_BTN-1){1'b0}}, 1'b1} << pat_q[idx_q];

  // x^16+x^14+x^13+x^11+1 in Fibonacci form: the feedback taps are bits 0,
  // 2, 3 and 5.  The shift is applied every cycle so the pattern depends on
  // the exact cycle at which each GEN step happens.
  assign lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign score_d = 10'(win_cnt_q * PTS);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    level_d     = level_q;
    round_cnt_d = round_cnt_q;
    win_cnt_d   = win_cnt_q;
    won_d       = won_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start && level_ok) begin
          level_d     = level;
          round_cnt_d = '0;
          win_cnt_d   = '0;
          idx_d       = '0;
          cnt_d       = '0;
          state_d     = S_GEN;
        end
      end
      S_GEN: begin
        // One element per cycle.  The RAM write itself is in the RAM process.
        if (idx_at_last) begin
          idx_d   = '0;
          cnt_d   = '0;
          state_d = S_SHOW_ON;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      S_SHOW_ON: begin
        if (tick) begin
          if (cnt_q == CW'(SHOW_TICKS - 1)) begin
            cnt_d   = '0;
            state_d = S_SHOW_OFF;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_SHOW_OFF: begin
        if (tick) begin
          cnt_d = '0;
          if (idx_at_last) begin
            idx_d   = '0;
            state_d = S_INPUT;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = S_SHOW_ON;
          end
        end
      end
      S_INPUT: begin
        // A press wins over a tick in the same cycle.  exp_btn is one-hot,
        // so equality also rejects multi-button presses.
        if (btn != '0) begin
          cnt_d = '0;
          if (btn == exp_btn) begin
            if (idx_at_last) begin
              won_d   = 1'b1;
              state_d = S_CHECK;
            end else begin
              idx_d = idx_q + AW'(1);
            end
          end else begin
            won_d   = 1'b0;
            state_d = S_CHECK;
          end
        end else if (tick) begin
          if (cnt_q == CW'(TIMEOUT_TICKS - 1)) begin
            won_d   = 1'b0;
            state_d = S_CHECK;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_CHECK: begin
        round_cnt_d = round_cnt_q + 6'd1;
        if (won_q) begin
          win_cnt_d = win_cnt_q + 6'd1;
        end
        idx_d   = '0;
        cnt_d   = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (tick) begin
          if (cnt_q == CW'(GAP_TICKS - 1)) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = (round_cnt_q == 6'(N_ROUNDS)) ? S_DONE : S_GEN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      lfsr_q      <= LFSR_SEED;
      idx_q       <= '0;
      cnt_q       <= '0;
      level_q     <= 3'b001;
      round_cnt_q <= '0;
      win_cnt_q   <= '0;
      score_q     <= '0;
      won_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      round_cnt_q <= round_cnt_d;
      win_cnt_q   <= win_cnt_d;
      score_q     <= score_d;
      won_q       <= won_d;
    end
  end

  // Pattern RAM: contents are only meaningful after GEN, so it has no reset.
  always_ff @(posedge clk) begin
    if (state_q == S_GEN) begin
      pat_q[idx_q] <= lfsr_q[BW-1:0];
    end
  end

  always_comb begin
    led = '0;
    case (state_q)
      S_SHOW_ON: led = exp_btn;
      S_INPUT:   led = btn;
      default:   led = '0;
    endcase
  end

  assign round_cnt  = round_cnt_q;
  assign win_cnt    = win_cnt_q;
  assign score      = score_q;
  assign round_win  = (state_q == S_CHECK) &&  won_q;
  assign round_lose = (state_q == S_CHECK) && !won_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign game_done  = (state_q == S_DONE);

endmodule

// File: tb/tb_memory_game_ctrl.sv
module tb_memory_game_ctrl;

  localparam int N_BTN         = 8;
  localparam int MAX_LEN       = 16;
  localparam int N_ROUNDS      = 10;
  localparam int SHOW_TICKS    = 5;
  localparam int TIMEOUT_TICKS = 100;
  localparam int PTS           = 10;
  localparam int GAP_TICKS     = 10;
  localparam int BW            = $clog2(N_BTN);
  localparam logic [15:0] SEED = 16'hACE1;

  logic             clk;
  logic             rst;
  logic             tick;
  logic             start;
  logic [2:0]       level;
  logic [N_BTN-1:0] btn;
  logic [N_BTN-1:0] led;
  logic [5:0]       round_cnt;
  logic [5:0]       win_cnt;
  logic [9:0]       score;
  logic             round_win;
  logic             round_lose;
  logic             busy;
  logic             game_done;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [15:0] m_lfsr;          // reference LFSR, one shift per clock edge
  int          pat[MAX_LEN];    // reference pattern of the current round
  int          m_rc;
  int          m_wc;

  memory_game_ctrl #(
    .N_BTN(N_BTN), .MAX_LEN(MAX_LEN), .N_ROUNDS(N_ROUNDS),
    .SHOW_TICKS(SHOW_TICKS), .TIMEOUT_TICKS(TIMEOUT_TICKS), .PTS(PTS)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .level(level),
    .btn(btn), .led(led), .round_cnt(round_cnt), .win_cnt(win_cnt),
    .score(score), .round_win(round_win), .round_lose(round_lose),
    .busy(busy), .game_done(game_done)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference helpers ----------------
  // Polynomial x^16+x^14+x^13+x^11+1: the taps 16,14,13,11 map to the
  // right-shift register bits 0,2,3,5 (mask 16'h002D).
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {^(v & 16'h002D), v[15:1]};
  endfunction

  function automatic logic [N_BTN-1:0] bit_of(input int k);
    logic [N_BTN-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  function automatic int wrong_of(input int right);
    int w;
    w = int'($urandom_range(0, N_BTN - 1));
    if (w == right) w = (w + 1) % N_BTN;
    return w;
  endfunction

  function automatic logic [N_BTN-1:0] noise();
    return N_BTN'($urandom_range(1, (1 << N_BTN) - 1));
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic advance();
    @(posedge clk);
    #1;
    tick  = 1'b0;
    btn   = '0;
    start = 1'b0;
    if (rst) m_lfsr = lfsr_next(m_lfsr);
  endtask

  task automatic step(input logic t, input logic [N_BTN-1:0] b, input logic s);
    tick  = t;
    btn   = b;
    start = s;
    advance();
  endtask

  // Press while replaying: led must follow btn in the same cycle.
  task automatic press(input logic [N_BTN-1:0] v, input logic t);
    tick = t;
    btn  = v;
    #1;
    check("led_mirror", led, v);
    advance();
  endtask

  // Button noise in a state where buttons have no effect.
  task automatic quiet_step(input logic t);
    tick = t;
    btn  = noise();
    #1;
    check("led_quiet", led, '0);
    advance();
  endtask

  // Called right after the edge that entered GEN.
  task automatic load_pattern(input int len);
    logic [15:0] v;
    v = m_lfsr;
    for (int i = 0; i < len; i++) begin
      pat[i] = int'(v[BW-1:0]);
      v      = lfsr_next(v);
    end
  endtask

  task automatic gen_show(input int len, input logic poke);
    load_pattern(len);
    for (int i = 0; i < len; i++) begin
      check("gen_led", led, '0);
      check("gen_busy", busy, 1'b1);
      if (i == 1) check("score_settled", score, m_wc * PTS);
      if (poke && i == 1) begin
        level = 3'b100;
        step(1'b0, '0, 1'b1);
      end else begin
        step(1'b0, '0, 1'b0);
      end
    end
    for (int j = 0; j < len; j++) begin
      for (int k = 0; k < SHOW_TICKS; k++) begin
        check("show_on", led, bit_of(pat[j]));
        repeat ($urandom_range(0, 1)) begin
          step(1'b0, noise(), 1'b0);
          check("show_hold", led, bit_of(pat[j]));
        end
        step(1'b1, '0, 1'b0);
      end
      check("show_off", led, '0);
      repeat ($urandom_range(0, 1)) begin
        step(1'b0, '0, 1'b0);
        check("show_off_hold", led, '0);
      end
      step(1'b1, '0, 1'b0);
    end
    check("input_led", led, '0);
    check("input_busy", busy, 1'b1);
  endtask

  task automatic play_ok(input int upto);
    for (int i = 0; i < upto; i++) begin
      repeat ($urandom_range(0, 2)) step($urandom_range(0, 3) == 0, '0, 1'b0);
      press(bit_of(pat[i]), 1'(($urandom_range(0, 1))));
    end
  endtask

  // Called right after the edge that entered CHECK.
  task automatic end_round(input logic won);
    int prev_wc;
    check("round_win", round_win, won);
    check("round_lose", round_lose, !won);
    prev_wc = m_wc;
    m_rc++;
    if (won) m_wc++;
    quiet_step(1'b0);
    check("round_cnt", round_cnt, m_rc);
    check("win_cnt", win_cnt, m_wc);
    check("pulse_once", {round_win, round_lose}, 2'b00);
    check("score_lag", score, prev_wc * PTS);
    quiet_step(1'b0);
    check("score", score, m_wc * PTS);
    for (int g = 0; g < GAP_TICKS; g++) begin
      check("gap_busy", busy, 1'b1);
      repeat ($urandom_range(0, 1)) quiet_step(1'b0);
      quiet_step(1'b1);
    end
    if (m_rc == N_ROUNDS) begin
      check("game_done", game_done, 1'b1);
      check("done_busy", busy, 1'b0);
      check("done_score", score, m_wc * PTS);
    end else begin
      check("next_round_busy", busy, 1'b1);
      check("next_round_done", game_done, 1'b0);
    end
  endtask

  // ---------------- directed/random sequence ----------------
  initial begin
    int mode;
    int k;
    rst    = 1'b0;
    tick   = 1'b0;
    start  = 1'b0;
    btn    = '0;
    level  = 3'b000;
    m_lfsr = SEED;
    m_rc   = 0;
    m_wc   = 0;
    repeat (3) advance();
    check("rst_led", led, '0);
    check("rst_round_cnt", round_cnt, '0);
    check("rst_win_cnt", win_cnt, '0);
    check("rst_score", score, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", game_done, 1'b0);
    check("rst_pulses", {round_win, round_lose}, 2'b00);
    check("rst_lfsr", dut.lfsr_q, SEED);
    rst = 1'b1;

    // Invalid levels and presses in IDLE are ignored.
    level = 3'b011;
    step(1'b0, '0, 1'b1);
    check("bad_level_011", busy, 1'b0);
    level = 3'b000;
    step(1'b0, '0, 1'b1);
    check("bad_level_000", busy, 1'b0);
    check("bad_level_done", game_done, 1'b0);
    quiet_step(1'b1);

    // Game A: level 001, ten correct rounds; start while busy is ignored.
    level = 3'b001;
    m_rc  = 0;
    m_wc  = 0;
    step(1'b0, '0, 1'b1);
    check("start_busy", busy, 1'b1);
    for (int r = 0; r < N_ROUNDS; r++) begin
      gen_show(MAX_LEN / 2, r == 0);
      play_ok(MAX_LEN / 2);
      end_round(1'b1);
    end
    check("game_a_score", score, 10'd100);

    // Game B: restart from DONE at level 100.
    level = 3'b100;
    m_rc  = 0;
    m_wc  = 0;
    step(1'b0, '0, 1'b1);
    check("restart_busy", busy, 1'b1);
    check("restart_done", game_done, 1'b0);
    check("restart_round_cnt", round_cnt, '0);
    check("restart_win_cnt", win_cnt, '0);
    gen_show(MAX_LEN, 1'b0);
    play_ok(2);
    press(bit_of(wrong_of(pat[2])), 1'b0);
    end_round(1'b0);
    gen_show(MAX_LEN, 1'b0);
    play_ok(int'($urandom_range(0, 5)));
    press(8'b00000011, 1'b0);
    end_round(1'b0);

    // Round 3: reset during SHOW_ON.
    load_pattern(MAX_LEN);
    repeat (MAX_LEN) step(1'b0, '0, 1'b0);
    step(1'b1, '0, 1'b0);
    check("pre_reset_led", led, bit_of(pat[0]));
    rst = 1'b0;
    #1;
    check("async_rst_led", led, '0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_round_cnt", round_cnt, '0);
    check("async_rst_score", score, '0);
    check("async_rst_lfsr", dut.lfsr_q, SEED);
    m_lfsr = SEED;
    repeat (2) advance();
    check("held_rst_pulses", {round_win, round_lose}, 2'b00);
    check("held_rst_lfsr", dut.lfsr_q, SEED);
    rst = 1'b1;

    // Game C: level 010, timeout behaviour then random rounds.
    level = 3'b010;
    m_rc  = 0;
    m_wc  = 0;
    step(1'b0, '0, 1'b1);
    gen_show(3 * MAX_LEN / 4, 1'b0);
    repeat (TIMEOUT_TICKS - 2) step(1'b1, '0, 1'b0);
    check("tmo_98_alive", round_lose, 1'b0);
    press(bit_of(pat[0]), 1'b1);
    check("tmo_press_alive", busy, 1'b1);
    check("tmo_press_no_lose", round_lose, 1'b0);
    repeat (TIMEOUT_TICKS - 1) step(1'b1, '0, 1'b0);
    check("tmo_99_no_lose", round_lose, 1'b0);
    step(1'b1, '0, 1'b0);
    end_round(1'b0);
    for (int r = 1; r < N_ROUNDS; r++) begin
      gen_show(3 * MAX_LEN / 4, 1'b0);
      mode = int'($urandom_range(0, 3));
      if (mode <= 1) begin
        play_ok(3 * MAX_LEN / 4);
        end_round(1'b1);
      end else if (mode == 2) begin
        k = int'($urandom_range(0, 3 * MAX_LEN / 4 - 1));
        play_ok(k);
        press(bit_of(wrong_of(pat[k])), 1'(($urandom_range(0, 1))));
        end_round(1'b0);
      end else begin
        k = int'($urandom_range(0, 3 * MAX_LEN / 4 - 1));
        play_ok(k);
        press(bit_of(pat[k]) | bit_of(wrong_of(pat[k])), 1'b0);
        end_round(1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/memory_game_ctrl.md
MEMORY_GAME_CTRL -- requirements
Module: memory_game_ctrl

Interface
REQ-001 The block SHALL have parameter N_BTN, default 8, meaning the button/LED channel count; it must be a power of 2 in the range 2..16.
REQ-002 The block SHALL have parameter MAX_LEN, default 16, meaning the pattern length at level 3; it must be a multiple of 4 in the range 4..32.
REQ-003 The block SHALL have parameter N_ROUNDS, default 10, meaning the number of rounds per game.
REQ-004 The block SHALL have parameter SHOW_TICKS, default 5, meaning the LED on-time per pattern element, counted in ticks.
REQ-005 The block SHALL have parameter TIMEOUT_TICKS, default 100, meaning the ticks allowed between presses before the round is lost.
REQ-006 The block SHALL have parameter PTS, default 10, meaning the points awarded per won round.
REQ-007 The block SHALL have ports as follows, one per line, as name, direction, width, meaning:
- clk, in, 1: the single clock.
- rst, in, 1: asynchronous, active-low reset.
- tick, in, 1: 1-cycle timing strobe (10 Hz).
- start, in, 1: 1-cycle game start request.
- level, in, 3: one-hot level (001, 010 or 100), sampled on start.
- btn, in, N_BTN: debounced 1-cycle press pulses.
- led, out, N_BTN: pattern display.
- round_cnt, out, 6: completed rounds.
- win_cnt, out, 6: won rounds.
- score, out, 10: win_cnt*PTS.
- round_win, out, 1: 1-cycle pulse on a won round.
- round_lose, out, 1: 1-cycle pulse on a lost round.
- busy, out, 1: high when not IDLE and not DONE.
- game_done, out, 1: high in DONE.

Function
REQ-008 The FSM SHALL have the states IDLE, GEN, SHOW_ON, SHOW_OFF, INPUT, CHECK, GAP and DONE.
REQ-009 In IDLE, start with a valid one-hot level SHALL latch the level, clear round_cnt/win_cnt, and go to GEN on the next cycle; start with any other level SHALL be ignored and the FSM stays in IDLE.
REQ-010 The pattern length L SHALL be MAX_LEN/2 for level 001, 3*MAX_LEN/4 for level 010, and MAX_LEN for level 100 (8/12/16 at the defaults).
REQ-011 A 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1) SHALL advance every clk cycle and never reach zero.
REQ-012 GEN SHALL take exactly L cycles, storing element i = the low log2(N_BTN) LFSR bits into pattern RAM[i], and then go to SHOW_ON with the element index at 0.
REQ-013 SHOW_ON SHALL drive led one-hot at bit RAM[idx] for SHOW_TICKS ticks; SHOW_OFF SHALL drive led to 0 for 1 tick, then either increment idx and return to SHOW_ON, or go to INPUT after element L-1.
REQ-014 In INPUT, led SHALL mirror btn, presses SHALL be ignored in all other states, and the index and timeout counter SHALL reset on entry.
REQ-015 A single-bit btn equal to one-hot(RAM[idx]) SHALL be correct and SHALL increment idx and clear the timeout.
REQ-016 A single-bit btn that mismatches, or a btn with multiple bits set, SHALL be wrong and SHALL end the round immediately as a loss.
REQ-017 A timeout counter reaching TIMEOUT_TICKS with no press SHALL be a loss; a tick and a press in the same cycle SHALL count as the press, with the timeout cleared.
REQ-018 The round SHALL be won when the L-th correct press occurs.
REQ-019 CHECK SHALL last 1 cycle, pulse round_win or round_lose, increment round_cnt, increment win_cnt if the round was won, and go to GAP.
REQ-020 GAP SHALL hold led at 0 for 10 ticks, then go to DONE if round_cnt equals N_ROUNDS, otherwise to GEN.
REQ-021 score SHALL be registered, updated 1 cycle after win_cnt, and equal win_cnt*PTS with no overflow (max 63*PTS must fit 10 bits).
REQ-022 DONE SHALL hold score, and start in DONE SHALL behave as in IDLE (restart).
REQ-023 start SHALL be ignored while busy is high.

Reset
REQ-024 rst low SHALL asynchronously force IDLE, set led, round_cnt, win_cnt, score, round_win, round_lose, busy and game_done to 0, reset the LFSR to its seed, and clear idx and all tick counters.
REQ-025 Reset mid-round SHALL abandon the round with no CHECK pulse.
REQ-026 Release of rst SHALL take effect on the first clk edge after deassertion.

Verification
REQ-027 Scenario: start with level=001, then the bench replays the 8 displayed LEDs correctly -> round_win pulses once, round_cnt=1, win_cnt=1, score=10 one cycle later.
REQ-028 Scenario: level=100, and the 3rd press is a wrong button -> round_lose pulses, no further presses are consumed, round_cnt=1, win_cnt=0.
REQ-029 Scenario: level=010 with no presses -> round_lose pulses after 100 ticks in INPUT; a press landing on the 99th tick instead keeps the round alive.
REQ-030 Scenario: 10 rounds of correct replay at level 001 -> game_done=1, score=100, busy=0; start in DONE restarts with score=0.
REQ-031 Scenario: start with level=011 or 000 -> stays in IDLE, busy=0; btn=8'b00000011 in INPUT -> loss.
REQ-032 Scenario: rst pulsed low during SHOW_ON -> led=0 and IDLE immediately (asynchronously), LFSR=16'hACE1, and the first GEN after restart reproduces the reset-seed pattern.
